// File: rtl/ongoru_guncelleme_denetleyici_pkg.sv
// ongoru_paket: shared types for the branch-predictor update scheduler.
//   BUYRUK_BIT           instruction / address width
//   guncelleme_girdisi_t one resolved control-flow update (98 bits)
//   durum_t              scheduler FSM states
package ongoru_paket;

    localparam int BUYRUK_BIT = 32;

    typedef struct packed {
        logic [BUYRUK_BIT-1:0] buyruk;
        logic [BUYRUK_BIT-1:0] adres;
        logic                  atladi;
        logic [BUYRUK_BIT-1:0] hedef;
        logic                  yanlis;
    } guncelleme_girdisi_t;

    typedef enum logic [1:0] {
        BOSTA  = 2'd0,
        BOSALT = 2'd1,
        KURTAR = 2'd2
    } durum_t;

    localparam logic [15:0] SAYAC_DOYMA = 16'hFFFF;

endpackage

// File: rtl/ongoru_guncelleme_denetleyici_fifo.sv
// guncelleme_fifo: synchronous FIFO holding accepted predictor updates.
// Ports:
//   clk_g, rst_g   clock, synchronous active-low reset
//   yaz_i, veri_i  write request and data (ignored when full or clearing)
//   oku_i          pop head (ignored when empty or clearing)
//   temizle_i      drop all entries; wins over write and pop
//   veri_o         current head entry
//   dolu_o, bos_o  full / empty flags
//   sayi_o         number of stored entries
module guncelleme_fifo #(
    parameter int GENISLIK = 98,
    parameter int DERINLIK = 4
) (
    input  logic                        clk_g,
    input  logic                        rst_g,
    input  logic                        yaz_i,
    input  logic                        oku_i,
    input  logic                        temizle_i,
    input  logic [GENISLIK-1:0]         veri_i,
    output logic [GENISLIK-1:0]         veri_o,
    output logic                        dolu_o,
    output logic                        bos_o,
    output logic [$clog2(DERINLIK):0]   sayi_o
);

    localparam int AW = $clog2(DERINLIK);
    localparam logic [AW:0] PTR_BIR = {{AW{1'b0}}, 1'b1};

    logic [GENISLIK-1:0] bellek_q [DERINLIK];
    logic [AW:0]         yaz_ptr_q, yaz_ptr_d;
    logic [AW:0]         oku_ptr_q, oku_ptr_d;
    logic                yaz_et, oku_et;

    // Pointers carry one extra wrap bit: equal -> empty, only MSB differs -> full.
    assign bos_o  = (yaz_ptr_q == oku_ptr_q);
    assign dolu_o = (yaz_ptr_q[AW] != oku_ptr_q[AW]) &&
                    (yaz_ptr_q[AW-1:0] == oku_ptr_q[AW-1:0]);
    assign sayi_o = yaz_ptr_q - oku_ptr_q;
    assign veri_o = bellek_q[oku_ptr_q[AW-1:0]];

    assign yaz_et = yaz_i && !dolu_o && !temizle_i;
    assign oku_et = oku_i && !bos_o && !temizle_i;

    always_comb begin
        yaz_ptr_d = yaz_ptr_q;
        oku_ptr_d = oku_ptr_q;
        if (temizle_i) begin
            yaz_ptr_d = '0;
            oku_ptr_d = '0;
        end else begin
            if (yaz_et) yaz_ptr_d = yaz_ptr_q + PTR_BIR;
            if (oku_et) oku_ptr_d = oku_ptr_q + PTR_BIR;
        end
    end

    always_ff @(posedge clk_g) begin
        if (!rst_g) begin
            yaz_ptr_q <= '0;
            oku_ptr_q <= '0;
        end else begin
            yaz_ptr_q <= yaz_ptr_d;
            oku_ptr_q <= oku_ptr_d;
        end
    end

    always_ff @(posedge clk_g) begin
        if (yaz_et) bellek_q[yaz_ptr_q[AW-1:0]] <= veri_i;
    end

endmodule

// File: rtl/ongoru_guncelleme_denetleyici.sv
// ongoru_guncelleme_denetleyici: schedules resolved branch/jump updates into the
// predictor's single update port.
// Ports:
//   clk_g, rst_g                 clock, synchronous active-low reset
//   i_gecerli0/1, o_hazir0/1     requester handshake (branch unit = 0, jump unit = 1)
//   i_buyruk/adres/atladi/hedef/yanlis0/1   resolved update fields
//   i_boru_temizle               pipeline flush
//   o_guncelle_gecerli_g + o_eski_buyruk, o_eski_buyruk_adresi, o_buyruk_atladi,
//   o_atlanan_adres, o_ongoru_yanlis       registered update pulse and its fields
//   o_getir_durdur               fetch stall while predictor state recovers
//   o_yanlis_sayaci              saturating count of issued mispredicts
//   o_durum                      current FSM state (debug)
// Handshake: an update transfers in a cycle where i_gecerliN and o_hazirN are both
// high. o_hazirN is a combinational grant, so i_gecerliN must not depend on it.
module ongoru_guncelleme_denetleyici
    import ongoru_paket::*;
#(
    parameter int DERINLIK        = 4,
    parameter int KURTARMA_CEVRIM = 2
) (
    input  logic                  clk_g,
    input  logic                  rst_g,
    input  logic                  i_gecerli0,
    input  logic                  i_gecerli1,
    output logic                  o_hazir0,
    output logic                  o_hazir1,
    input  logic [BUYRUK_BIT-1:0] i_buyruk0,
    input  logic [BUYRUK_BIT-1:0] i_buyruk1,
    input  logic [BUYRUK_BIT-1:0] i_adres0,
    input  logic [BUYRUK_BIT-1:0] i_adres1,
    input  logic                  i_atladi0,
    input  logic                  i_atladi1,
    input  logic [BUYRUK_BIT-1:0] i_hedef0,
    input  logic [BUYRUK_BIT-1:0] i_hedef1,
    input  logic                  i_yanlis0,
    input  logic                  i_yanlis1,
    input  logic                  i_boru_temizle,
    output logic                  o_guncelle_gecerli_g,
    output logic [BUYRUK_BIT-1:0] o_eski_buyruk,
    output logic [BUYRUK_BIT-1:0] o_eski_buyruk_adresi,
    output logic                  o_buyruk_atladi,
    output logic [BUYRUK_BIT-1:0] o_atlanan_adres,
    output logic                  o_ongoru_yanlis,
    output logic                  o_getir_durdur,
    output logic [15:0]           o_yanlis_sayaci,
    output durum_t                o_durum
);

    localparam int AW = $clog2(DERINLIK);
    localparam int SW = (KURTARMA_CEVRIM > 1) ? $clog2(KURTARMA_CEVRIM) : 1;
    localparam int GW = $bits(guncelleme_girdisi_t);
    localparam logic [SW-1:0] KURTAR_YUKLE = SW'(KURTARMA_CEVRIM - 1);
    localparam logic [AW:0]   TEK_GIRDI    = {{AW{1'b0}}, 1'b1};

    durum_t              durum_q, durum_d;
    logic                oncelik_q, oncelik_d;     // 0: req0 holds priority
    logic [SW-1:0]       sayac_q, sayac_d;         // remaining recovery cycles - 1
    logic                kabul, hak0, hak1, yaz, oku, fifo_temizle, yanlis_pop;
    guncelleme_girdisi_t girdi0, girdi1, yazilan, bas;
    logic [GW-1:0]       bas_ham;
    logic                dolu, bos;
    logic [AW:0]         sayi;

    logic                  guncelle_q;
    logic [BUYRUK_BIT-1:0] buyruk_q, adres_q, hedef_q;
    logic                  atladi_q, yanlis_q;
    logic [15:0]           yanlis_sayaci_q;

    assign girdi0  = '{buyruk: i_buyruk0, adres: i_adres0, atladi: i_atladi0,
                       hedef: i_hedef0, yanlis: i_yanlis0};
    assign girdi1  = '{buyruk: i_buyruk1, adres: i_adres1, atladi: i_atladi1,
                       hedef: i_hedef1, yanlis: i_yanlis1};
    assign yazilan = hak1 ? girdi1 : girdi0;
    assign yaz     = hak0 || hak1;
    assign bas     = guncelleme_girdisi_t'(bas_ham);

    guncelleme_fifo #(
        .GENISLIK (GW),
        .DERINLIK (DERINLIK)
    ) u_fifo (
        .clk_g     (clk_g),
        .rst_g     (rst_g),
        .yaz_i     (yaz),
        .oku_i     (oku),
        .temizle_i (fifo_temizle),
        .veri_i    (yazilan),
        .veri_o    (bas_ham),
        .dolu_o    (dolu),
        .bos_o     (bos),
        .sayi_o    (sayi)
    );

    // Round-robin arbiter. Full is taken before this cycle's pop, so a full
    // FIFO refuses a write even while it pops.
    always_comb begin
        kabul = rst_g && !dolu && (durum_q != KURTAR) && !i_boru_temizle;
        hak0  = 1'b0;
        hak1  = 1'b0;
        if (kabul) begin
            if (i_gecerli0 && i_gecerli1) begin
                hak0 = !oncelik_q;
                hak1 = oncelik_q;
            end else begin
                hak0 = i_gecerli0;
                hak1 = i_gecerli1;
            end
        end
        oncelik_d = oncelik_q;
        if (hak0)      oncelik_d = 1'b1;
        else if (hak1) oncelik_d = 1'b0;
    end

    always_comb begin
        durum_d      = durum_q;
        sayac_d      = sayac_q;
        oku          = 1'b0;
        yanlis_pop   = 1'b0;
        fifo_temizle = i_boru_temizle;
        case (durum_q)
            BOSTA: begin
                if (yaz) durum_d = BOSALT;
            end
            BOSALT: begin
                oku = !bos && !i_boru_temizle;
                if (oku && bas.yanlis) begin
                    // Younger entries (including one written this cycle) were
                    // fetched down the wrong path.
                    yanlis_pop   = 1'b1;
                    fifo_temizle = 1'b1;
                    sayac_d      = KURTAR_YUKLE;
                    durum_d      = KURTAR;
                end else if (oku && (sayi == TEK_GIRDI) && !yaz) begin
                    durum_d = BOSTA;
                end
            end
            KURTAR: begin
                if (sayac_q == '0) durum_d = BOSTA;
                else               sayac_d = sayac_q - SW'(1);
            end
            default: durum_d = BOSTA;
        endcase
        if (i_boru_temizle) durum_d = BOSTA;
    end

    always_ff @(posedge clk_g) begin
        if (!rst_g) begin
            durum_q   <= BOSTA;
            oncelik_q <= 1'b0;
            sayac_q   <= '0;
        end else begin
            durum_q   <= durum_d;
            oncelik_q <= oncelik_d;
            sayac_q   <= sayac_d;
        end
    end

    // Output registers: fields load only on a pop and hold otherwise.
    always_ff @(posedge clk_g) begin
        if (!rst_g) begin
            guncelle_q      <= 1'b0;
            buyruk_q        <= '0;
            adres_q         <= '0;
            atladi_q        <= 1'b0;
            hedef_q         <= '0;
            yanlis_q        <= 1'b0;
            yanlis_sayaci_q <= '0;
        end else begin
            guncelle_q <= oku;
            if (oku) begin
                buyruk_q <= bas.buyruk;
                adres_q  <= bas.adres;
                atladi_q <= bas.atladi;
                hedef_q  <= bas.hedef;
                yanlis_q <= bas.yanlis;
            end
            if (yanlis_pop && (yanlis_sayaci_q != SAYAC_DOYMA))
                yanlis_sayaci_q <= yanlis_sayaci_q + 16'd1;
        end
    end

    assign o_hazir0             = hak0;
    assign o_hazir1             = hak1;
    assign o_guncelle_gecerli_g = guncelle_q;
    assign o_eski_buyruk        = buyruk_q;
    assign o_eski_buyruk_adresi = adres_q;
    assign o_buyruk_atladi      = atladi_q;
    assign o_atlanan_adres      = hedef_q;
    assign o_ongoru_yanlis      = yanlis_q;
    assign o_getir_durdur       = (durum_q == KURTAR);  // rises with the mispredict pulse
    assign o_yanlis_sayaci      = yanlis_sayaci_q;
    assign o_durum              = durum_q;

endmodule
